// File: rtl/sysbus_pkg.sv
// Shared MERA-400 system bus types.
// State encoding, response bundle and alarm timing default.
package sysbus_pkg;

  localparam int ALARM_CYCLES_DEF = 800;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE,
    FINISH,
    ABORT
  } state_t;

  typedef struct packed {
    logic ok;
    logic en;
    logic pe;
  } resp_t;

endpackage

// File: rtl/sysbus_master_bus_timer.sv
// Loadable saturating down-counter for bus phase timing.
// expire is high whenever the count sits at zero.
module bus_timer #(
  parameter int W = 10
) (
  input  logic         clk_sys,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (clr)
      cnt <= '0;
    else if (load)
      cnt <= val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/sysbus_master.sv
// CPU-side MERA-400 bus sequencer: one four-phase
// read or write per start, with EN/PE/alarm reporting.
import sysbus_pkg::*;

module sysbus_master #(
  parameter int ALARM_CYCLES = ALARM_CYCLES_DEF,
  parameter int SETUP_CYCLES = 2
) (
  input  logic        clk_sys,
  input  logic        clm,
  input  logic        start,
  input  logic        wr,
  input  logic [3:0]  nb,
  input  logic        q,
  input  logic [15:0] ad,
  input  logic [15:0] dt,
  input  logic        rok,
  input  logic        ren,
  input  logic        rpe,
  input  logic [15:0] rdt,
  output logic [3:0]  dnb,
  output logic        dqb,
  output logic [15:0] dad,
  output logic [15:0] ddt,
  output logic        dw,
  output logic        dr,
  output logic        busy,
  output logic        done,
  output logic        no_mem,
  output logic        par_err,
  output logic        alarm,
  output logic [15:0] rdata
);

  localparam int TW = $clog2(ALARM_CYCLES + 1);
  localparam logic [TW-1:0] T_ALARM = TW'(ALARM_CYCLES - 1);
  localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYCLES - 1);

  state_t state, state_n;
  resp_t  rsp;
  logic   any_rsp;

  logic        l_wr;
  logic [3:0]  l_nb;
  logic        l_q;
  logic [15:0] l_ad;
  logic [15:0] l_dt;

  logic          t_clr;
  logic          t_load;
  logic          t_exp;
  logic [TW-1:0] t_val;

  assign rsp     = '{ok: rok, en: ren, pe: rpe};
  assign any_rsp = rsp.ok | rsp.en | rsp.pe;

  bus_timer #(.W(TW)) u_timer (
    .clk_sys (clk_sys),
    .clr     (t_clr),
    .load    (t_load),
    .val     (t_val),
    .expire  (t_exp)
  );

  // Timed states reload the timer on entry; others clear it.
  always_comb begin
    state_n = state;
    t_load  = 1'b0;
    t_val   = T_ALARM;
    unique case (state)
      IDLE:
        if (start) begin
          state_n = SETUP;
          t_load  = 1'b1;
          t_val   = T_SETUP;
        end
      SETUP:
        if (t_exp) begin
          state_n = STROBE;
          t_load  = 1'b1;
        end
      STROBE:
        if (any_rsp) begin
          state_n = RELEASE;
          t_load  = 1'b1;
        end else if (t_exp) begin
          state_n = ABORT;
        end
      RELEASE:
        if (!any_rsp)
          state_n = FINISH;
        else if (t_exp)
          state_n = ABORT;
      FINISH:  state_n = IDLE;
      ABORT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    t_clr = clm | ((state_n != state) & ~t_load);
  end

  always_ff @(posedge clk_sys) begin
    if (clm) begin
      state   <= IDLE;
      l_wr    <= 1'b0;
      l_nb    <= '0;
      l_q     <= 1'b0;
      l_ad    <= '0;
      l_dt    <= '0;
      no_mem  <= 1'b0;
      par_err <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        l_wr    <= wr;
        l_nb    <= nb;
        l_q     <= q;
        l_ad    <= ad;
        l_dt    <= dt;
        no_mem  <= 1'b0;
        par_err <= 1'b0;
      end
      // EN outranks OK: no data is taken from an absent module.
      if (state == STROBE && any_rsp) begin
        no_mem  <= rsp.en;
        par_err <= rsp.pe;
        if (rsp.ok && !rsp.en && !l_wr)
          rdata <= rdt;
      end
      if (state_n == ABORT) begin
        no_mem  <= 1'b0;
        par_err <= 1'b0;
      end
    end
  end

  logic drive;
  assign drive = (state == SETUP) || (state == STROBE)
              || (state == RELEASE);

  assign dnb   = drive ? l_nb : '0;
  assign dqb   = drive & l_q;
  assign dad   = drive ? l_ad : '0;
  assign ddt   = (drive && l_wr) ? l_dt : '0;
  assign dw    = (state == STROBE) & l_wr;
  assign dr    = (state == STROBE) & ~l_wr;
  assign busy  = (state != IDLE);
  assign done  = (state == FINISH);
  assign alarm = (state == ABORT);

endmodule

// File: tb/tb_sysbus_master.sv
// Scoreboard bench for sysbus_master: write, read,
// EN/PE, timeouts, clear-master abort and start collision.
module tb_sysbus_master;

  localparam int AC = 800;

  logic        clk_sys = 1'b0;
  logic        clm = 1'b1;
  logic        start = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  nb = '0;
  logic        q = 1'b0;
  logic [15:0] ad = '0;
  logic [15:0] dt = '0;
  logic        rok = 1'b0;
  logic        ren = 1'b0;
  logic        rpe = 1'b0;
  logic [15:0] rdt = '0;
  logic [3:0]  dnb;
  logic        dqb;
  logic [15:0] dad;
  logic [15:0] ddt;
  logic        dw;
  logic        dr;
  logic        busy;
  logic        done;
  logic        no_mem;
  logic        par_err;
  logic        alarm;
  logic [15:0] rdata;

  sysbus_master #(
    .ALARM_CYCLES (AC),
    .SETUP_CYCLES (2)
  ) dut (
    .clk_sys (clk_sys),
    .clm     (clm),
    .start   (start),
    .wr      (wr),
    .nb      (nb),
    .q       (q),
    .ad      (ad),
    .dt      (dt),
    .rok     (rok),
    .ren     (ren),
    .rpe     (rpe),
    .rdt     (rdt),
    .dnb     (dnb),
    .dqb     (dqb),
    .dad     (dad),
    .ddt     (ddt),
    .dw      (dw),
    .dr      (dr),
    .busy    (busy),
    .done    (done),
    .no_mem  (no_mem),
    .par_err (par_err),
    .alarm   (alarm),
    .rdata   (rdata)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        nm;
    logic        pe;
    logic [15:0] rd;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] m_rdata = '0;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_start(input logic w, input logic [3:0] n,
                          input logic qq, input logic [15:0] a,
                          input logic [15:0] d);
    step();
    start = 1'b1;
    wr = w;
    nb = n;
    q = qq;
    ad = a;
    dt = d;
    step();
    start = 1'b0;
  endtask

  task automatic push(input logic nm, input logic pe,
                      input logic [15:0] rd);
    exp_t e;
    e.nm = nm;
    e.pe = pe;
    e.rd = rd;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    bit   seen = 0;
    exp_t e;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_sys);
      if (done === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done: got no done within 20 cycles", nm);
      if (sbq.size() > 0) void'(sbq.pop_front());
      return;
    end
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: done with empty scoreboard", nm);
      return;
    end
    e = sbq.pop_front();
    n_tests++;
    if ({no_mem, par_err, rdata} !== {e.nm, e.pe, e.rd}) begin
      n_fail++;
      $display("FAIL %s_result: got nm=%b pe=%b rd=%h want nm=%b pe=%b rd=%h",
               nm, no_mem, par_err, rdata, e.nm, e.pe, e.rd);
    end
    n_tests++;
    if ({dw, dr, dad, ddt, dnb, dqb} !== '0) begin
      n_fail++;
      $display("FAIL %s_drv: drivers active at done dad=%h ddt=%h",
               nm, dad, ddt);
    end
    @(negedge clk_sys);
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_idle: got busy=%b done=%b want 0 0",
               nm, busy, done);
    end
  endtask

  task automatic bus_cycle(input string nm, input logic [15:0] a,
                           input logic ok, input logic en,
                           input logic pe, input logic [15:0] v);
    do_start(1'b0, 4'h2, 1'b0, a, 16'h0);
    step();
    step();
    {rok, ren, rpe} = {ok, en, pe};
    rdt = v;
    step();
    {rok, ren, rpe} = 3'b000;
    rdt = '0;
    wait_done(nm);
  endtask

  task automatic test_reset();
    clm = 1'b1;
    step();
    step();
    @(negedge clk_sys);
    n_tests++;
    if ({dnb, dqb, dad, ddt, dw, dr, busy, done,
         no_mem, par_err, alarm, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset: outputs nonzero busy=%b dad=%h rdata=%h",
               busy, dad, rdata);
    end
    step();
    clm = 1'b0;
  endtask

  task automatic test_write();
    bit bad = 0;
    push(1'b0, 1'b0, m_rdata);
    do_start(1'b1, 4'h3, 1'b1, 16'h1234, 16'hBEEF);
    @(negedge clk_sys);
    n_tests++;
    if ({dw, dr, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL wr_setup: got dw=%b dr=%b busy=%b want 0 0 1",
               dw, dr, busy);
    end
    step();
    step();
    @(negedge clk_sys);
    n_tests++;
    if ({dw, dr} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_strobe: got dw=%b dr=%b want 1 0", dw, dr);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      if ({dad, ddt, dnb, dqb, dw} !== {16'h1234, 16'hBEEF, 4'h3, 2'b11})
        bad = 1;
      step();
    end
    rok = 1'b1;
    @(negedge clk_sys);
    if ({dad, ddt, dnb, dqb, dw} !== {16'h1234, 16'hBEEF, 4'h3, 2'b11})
      bad = 1;
    step();
    @(negedge clk_sys);
    n_tests++;
    if ({dad, ddt, dnb, dqb, dw} !== {16'h1234, 16'hBEEF, 4'h3, 2'b10}) begin
      n_fail++;
      $display("FAIL wr_release: got dad=%h ddt=%h dw=%b want 1234 beef 0",
               dad, ddt, dw);
    end
    step();
    rok = 1'b0;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL wr_lines: got bad lines during strobe want stable");
    end
    wait_done("write");
  endtask

  task automatic test_read();
    m_rdata = 16'hCAFE;
    push(1'b0, 1'b0, m_rdata);
    do_start(1'b0, 4'h1, 1'b0, 16'h00FF, 16'h7777);
    step();
    step();
    @(negedge clk_sys);
    n_tests++;
    if ({dr, dw, ddt, dad} !== {2'b10, 16'h0, 16'h00FF}) begin
      n_fail++;
      $display("FAIL rd_strobe: got dr=%b dw=%b ddt=%h dad=%h",
               dr, dw, ddt, dad);
    end
    step();
    rok = 1'b1;
    rdt = 16'hCAFE;
    step();
    rok = 1'b0;
    rdt = '0;
    @(negedge clk_sys);
    n_tests++;
    if ({dr, ddt, dad} !== {1'b0, 16'h0, 16'h00FF}) begin
      n_fail++;
      $display("FAIL rd_release: got dr=%b ddt=%h dad=%h", dr, ddt, dad);
    end
    wait_done("read");
  endtask

  task automatic test_en_pe();
    push(1'b1, 1'b0, m_rdata);
    bus_cycle("en", 16'h0100, 1'b0, 1'b1, 1'b0, 16'h1111);
    m_rdata = 16'h5555;
    push(1'b0, 1'b1, m_rdata);
    bus_cycle("okpe", 16'h0200, 1'b1, 1'b0, 1'b1, 16'h5555);
    push(1'b1, 1'b0, m_rdata);
    bus_cycle("oken", 16'h0300, 1'b1, 1'b1, 1'b0, 16'h2222);
  endtask

  task automatic check_abort(input string nm);
    @(negedge clk_sys);
    n_tests++;
    if ({alarm, done, busy, no_mem, par_err} !== 5'b10100
        || {dw, dr, dad, ddt, dnb, dqb} !== '0) begin
      n_fail++;
      $display("FAIL %s_alarm: got al=%b dn=%b bz=%b nm=%b pe=%b dad=%h",
               nm, alarm, done, busy, no_mem, par_err, dad);
    end
  endtask

  task automatic check_after(input string nm, input bit bad_done);
    n_tests++;
    if (bad_done) begin
      n_fail++;
      $display("FAIL %s_nodone: got done pulse want none", nm);
    end
    step();
    @(negedge clk_sys);
    n_tests++;
    if ({busy, alarm} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_idle: got busy=%b alarm=%b want 0 0",
               nm, busy, alarm);
    end
  endtask

  task automatic test_timeout();
    bit bad_done = 0;
    do_start(1'b0, 4'h5, 1'b0, 16'h0ABC, 16'h0);
    step();
    step();
    for (int i = 0; i < AC - 1; i++) begin
      @(negedge clk_sys);
      if (done) bad_done = 1;
      step();
    end
    @(negedge clk_sys);
    n_tests++;
    if ({alarm, dr} !== 2'b01) begin
      n_fail++;
      $display("FAIL to_early: got alarm=%b dr=%b want 0 1", alarm, dr);
    end
    step();
    check_abort("to");
    check_after("to", bad_done);
  endtask

  task automatic test_stuck_release();
    bit bad_done = 0;
    do_start(1'b0, 4'h6, 1'b1, 16'h0DEF, 16'h0);
    step();
    step();
    rok = 1'b1;
    rpe = 1'b1;
    rdt = 16'h1357;
    step();
    for (int i = 0; i < AC - 1; i++) begin
      @(negedge clk_sys);
      if (done) bad_done = 1;
      step();
    end
    @(negedge clk_sys);
    n_tests++;
    if ({alarm, dr, dad, par_err} !== {2'b00, 16'h0DEF, 1'b1}) begin
      n_fail++;
      $display("FAIL rel_early: got al=%b dr=%b dad=%h pe=%b",
               alarm, dr, dad, par_err);
    end
    step();
    check_abort("rel");
    rok = 1'b0;
    rpe = 1'b0;
    rdt = '0;
    check_after("rel", bad_done);
  endtask

  task automatic test_clm_abort();
    do_start(1'b1, 4'h9, 1'b1, 16'h4321, 16'h8765);
    step();
    step();
    @(negedge clk_sys);
    n_tests++;
    if (dw !== 1'b1) begin
      n_fail++;
      $display("FAIL clm_pre: got dw=%b want 1", dw);
    end
    step();
    clm = 1'b1;
    step();
    clm = 1'b0;
    m_rdata = '0;
    @(negedge clk_sys);
    n_tests++;
    if ({dnb, dqb, dad, ddt, dw, dr, busy, done,
         no_mem, par_err, alarm, rdata} !== '0) begin
      n_fail++;
      $display("FAIL clm_abort: got busy=%b dw=%b dad=%h want all 0",
               busy, dw, dad);
    end
  endtask

  task automatic test_collision();
    m_rdata = 16'hA5A5;
    push(1'b0, 1'b0, m_rdata);
    do_start(1'b0, 4'h4, 1'b0, 16'h2222, 16'h0);
    start = 1'b1;
    wr = 1'b1;
    ad = 16'h9999;
    dt = 16'h3333;
    step();
    start = 1'b0;
    step();
    @(negedge clk_sys);
    n_tests++;
    if ({dr, dw, dad, ddt} !== {2'b10, 16'h2222, 16'h0}) begin
      n_fail++;
      $display("FAIL coll_addr: got dr=%b dw=%b dad=%h ddt=%h want 1 0 2222 0",
               dr, dw, dad, ddt);
    end
    step();
    rok = 1'b1;
    rdt = 16'hA5A5;
    step();
    rok = 1'b0;
    rdt = '0;
    wait_done("coll");
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %0d left want 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_en_pe();
    test_timeout();
    test_stuck_release();
    test_clm_abort();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
